// File: rtl/button_gesture_decoder.sv
// Turns a debounced button level into single-cycle gesture events:
// short click, long press, double click and auto-repeat while held.
module button_gesture_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 12_500_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_debounced,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse,
    output logic busy
);

    typedef enum logic [2:0] {
        ARM    = 3'd0,
        IDLE   = 3'd1,
        PRESS1 = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4,
        HELD   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Count of samples including the one being taken now; holds at all-ones.
    assign cnt_nx = (cnt == '1) ? cnt : cnt + ONE_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARM;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            repeat_pulse <= 1'b0;
            busy         <= 1'b1;
        end else begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                ARM: begin
                    // A button held through reset must be released before arming.
                    if (!pb_debounced) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (pb_debounced) begin
                        state <= PRESS1;
                        cnt   <= ONE_C;
                        busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (pb_debounced) begin
                        if (cnt_nx == LONG_C) begin
                            long_pulse <= 1'b1;
                            state      <= HELD;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end else if (GAP_CYCLES == 1) begin
                        // The release sample alone already closes the gap window.
                        short_pulse <= 1'b1;
                        state       <= IDLE;
                        cnt         <= '0;
                        busy        <= 1'b0;
                    end else begin
                        state <= GAP;
                        cnt   <= ONE_C;
                    end
                end
                GAP: begin
                    if (!pb_debounced) begin
                        if (cnt_nx == GAP_C) begin
                            short_pulse <= 1'b1;
                            state       <= IDLE;
                            cnt         <= '0;
                            busy        <= 1'b0;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end else begin
                        double_pulse <= 1'b1;
                        state        <= PRESS2;
                        cnt          <= '0;
                    end
                end
                PRESS2: begin
                    if (!pb_debounced) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                HELD: begin
                    if (!pb_debounced) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt_nx == REPEAT_C) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                default: begin
                    state <= ARM;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder: a per-cycle vector table for the
// main instance plus hand sequences, including a GAP_CYCLES=1 instance.
module tb_button_gesture_decoder;

    logic clk;
    logic rst;
    logic pb;
    logic short_pulse, long_pulse, double_pulse, repeat_pulse, busy;
    logic pb1;
    logic g1_short, g1_long, g1_double, g1_repeat, g1_busy;

    int n_checks = 0;
    int n_fail   = 0;

    button_gesture_decoder #(
        .LONG_CYCLES(8), .GAP_CYCLES(5), .REPEAT_CYCLES(4), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .pb_debounced(pb),
        .short_pulse(short_pulse), .long_pulse(long_pulse),
        .double_pulse(double_pulse), .repeat_pulse(repeat_pulse), .busy(busy)
    );

    button_gesture_decoder #(
        .LONG_CYCLES(3), .GAP_CYCLES(1), .REPEAT_CYCLES(2), .CNT_W(4)
    ) u_g1 (
        .clk(clk), .rst(rst), .pb_debounced(pb1),
        .short_pulse(g1_short), .long_pulse(g1_long),
        .double_pulse(g1_double), .repeat_pulse(g1_repeat), .busy(g1_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output codes: {short, long, double, repeat, busy}
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] B = 5'b00001;
    localparam logic [4:0] S = 5'b10000;
    localparam logic [4:0] L = 5'b01001;
    localparam logic [4:0] D = 5'b00101;
    localparam logic [4:0] R = 5'b00011;

    typedef struct {
        logic       rst;
        logic       pb;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic p, input logic [4:0] e, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{rst: r, pb: p, exp: e});
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step_g1(input logic p, input logic [4:0] e, input string name);
        @(negedge clk);
        pb1 = p;
        @(posedge clk);
        #1;
        check(name, {g1_short, g1_long, g1_double, g1_repeat, g1_busy}, e);
    endtask

    initial begin
        logic [4:0] got;
        int         lows;
        bit         found;

        rst = 1'b1;
        pb  = 1'b0;
        pb1 = 1'b0;

        // Short click: 3 high, 6 low
        add(1, 0, B, 1); add(0, 0, Z, 1);
        add(0, 1, B, 3); add(0, 0, B, 4); add(0, 0, S, 1); add(0, 0, Z, 1);
        // Double click: 3 high, 2 low, 3 high, low
        add(0, 1, B, 3); add(0, 0, B, 2); add(0, 1, D, 1); add(0, 1, B, 2); add(0, 0, Z, 2);
        // Second press on the last low sample of the gap window
        add(0, 1, B, 2); add(0, 0, B, 4); add(0, 1, D, 1); add(0, 0, Z, 1);
        // Long press with repeats, silent release
        add(0, 1, B, 7); add(0, 1, L, 1); add(0, 1, B, 3); add(0, 1, R, 1);
        add(0, 1, B, 3); add(0, 1, R, 1); add(0, 0, Z, 6);
        // Held through reset, then a normal click
        add(1, 1, B, 1); add(0, 1, B, 20); add(0, 0, Z, 1);
        add(0, 1, B, 3); add(0, 0, B, 4); add(0, 0, S, 1); add(0, 0, Z, 1);
        // Reset mid-PRESS1 while still held
        add(0, 1, B, 6); add(1, 1, B, 1); add(0, 1, B, 10); add(0, 0, Z, 2);
        // Reset mid-GAP suppresses the pending short click
        add(0, 1, B, 3); add(0, 0, B, 2); add(1, 0, B, 1); add(0, 0, Z, 6);
        // Long boundary: 7 high is short, 8 high is long
        add(0, 1, B, 7); add(0, 0, B, 4); add(0, 0, S, 1); add(0, 0, Z, 1);
        add(0, 1, B, 7); add(0, 1, L, 1); add(0, 0, Z, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            pb  = vecs[i].pb;
            @(posedge clk);
            #1;
            got = {short_pulse, long_pulse, double_pulse, repeat_pulse, busy};
            check($sformatf("vec%0d", i), got, vecs[i].exp);
            n_checks++;
            if ($countones(got[4:1]) > 1) begin
                n_fail++;
                $display("FAIL onehot vec%0d: got %b expected at most one pulse", i, got);
            end
        end

        // Bounded wait for the short pulse after a 3-sample press
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); pb = 1'b1;
        end
        found = 1'b0;
        lows  = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            pb = 1'b0;
            @(posedge clk);
            #1;
            lows = k;
            if (short_pulse) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL short_wait: no short_pulse within 20 low samples, required one at sample 5");
        end else if (lows != 5) begin
            n_fail++;
            $display("FAIL short_latency: got low sample %0d expected 5", lows);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        check("busy_after_short", {4'b0000, busy}, Z);

        // GAP_CYCLES=1 instance: release sample closes the click immediately
        step_g1(1'b1, B, "g1_press");
        step_g1(1'b0, S, "g1_short_first_low");
        step_g1(1'b0, Z, "g1_idle");
        step_g1(1'b1, B, "g1_hold1");
        step_g1(1'b1, B, "g1_hold2");
        step_g1(1'b1, L, "g1_long");
        step_g1(1'b1, B, "g1_held1");
        step_g1(1'b1, R, "g1_repeat");
        step_g1(1'b0, Z, "g1_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
